// File: rtl/bus_memory_responder.sv
// bus_memory_responder
//
// Shared-memory end of the CPU/cache bus. Serves read-miss and write-back
// requests from a small backing store, replying a fixed number of cycles
// after the request is captured.
//
// Handshake (4-phase): the bus raises req with req_write/req_address/req_data
// valid and holds them until it sees resp_valid. The responder captures the
// request only in IDLE, raises resp_valid LATENCY edges after capture, holds
// resp_valid/resp_data while req stays high, and drops resp_valid at the first
// edge where req is low.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   req          request valid from the bus
//   req_write    1 = write-back, 0 = read
//   req_address  target word address
//   req_data     write-back data
//   resp_valid   response available
//   resp_data    read data, or the written data for a write-back
//   busy         high whenever the FSM is not in IDLE
//   dbg_address  debug peek address
//   dbg_data     combinational view of mem[dbg_address]
module bus_memory_responder #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 4,
    parameter int LATENCY    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] dbg_address,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // Counter starts at LATENCY-1 so that ACK is entered LATENCY edges
    // after the capture edge.
    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            count_q, count_d;
    logic                  lat_write_q, lat_write_d;
    logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_WIDTH-1:0] lat_data_q, lat_data_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        lat_write_d  = lat_write_q;
        lat_addr_d   = lat_addr_q;
        lat_data_d   = lat_data_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        mem_d        = mem_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    lat_write_d = req_write;
                    lat_addr_d  = req_address;
                    lat_data_d  = req_data;
                    count_d     = COUNT_INIT;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // req is deliberately not looked at here: a request that is
                // withdrawn early still completes.
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    state_d      = ST_ACK;
                    resp_valid_d = 1'b1;
                    if (lat_write_q) begin
                        mem_d[lat_addr_q] = lat_data_q;
                        resp_data_d       = lat_data_q;
                    end else begin
                        resp_data_d = mem_q[lat_addr_q];
                    end
                end
            end
            ST_ACK: begin
                // resp_data intentionally keeps its last value on exit.
                if (!req) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                // Unused encoding recovers to IDLE.
                resp_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= 4'd0;
            lat_write_q  <= 1'b0;
            lat_addr_q   <= '0;
            lat_data_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_WIDTH'(i);
            end
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            lat_write_q  <= lat_write_d;
            lat_addr_q   <= lat_addr_d;
            lat_data_q   <= lat_data_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mem_q        <= mem_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign dbg_data   = mem_q[dbg_address];

endmodule

// File: tb/tb_bus_memory_responder.sv
module tb_bus_memory_responder;

  logic       clock;
  logic       reset;
  logic       req;
  logic       req_write;
  logic [2:0] req_address;
  logic [3:0] req_data;
  logic       resp_valid;
  logic [3:0] resp_data;
  logic       busy;
  logic [2:0] dbg_address;
  logic [3:0] dbg_data;

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0] exp_q[$];

  bus_memory_responder #(
    .ADDR_WIDTH(3),
    .DATA_WIDTH(4),
    .LATENCY(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_write  (req_write),
    .req_address(req_address),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy),
    .dbg_address(dbg_address),
    .dbg_data   (dbg_data)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // one rising edge, then settle before sampling
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic peek(input string name, input logic [2:0] a, input logic [3:0] exp);
    dbg_address = a;
    #1;
    check(name, dbg_data, exp);
  endtask

  // scoreboard: compare resp_data against the oldest expected entry
  task automatic score(input string name);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      check({name, "_sb"}, resp_data, exp_q.pop_front());
    end
  endtask

  // full well-behaved transaction at LATENCY=2
  task automatic do_txn(input string name, input logic w, input logic [2:0] a,
                        input logic [3:0] d, input logic [3:0] exp);
    req = 1'b1; req_write = w; req_address = a; req_data = d;
    exp_q.push_back(exp);
    step();  // E0: capture
    check({name, "_busy_e0"}, busy, 1);
    check({name, "_rv_e0"}, resp_valid, 0);
    step();  // E0+1
    check({name, "_rv_e1"}, resp_valid, 0);
    step();  // E0+2
    check({name, "_rv_e2"}, resp_valid, 1);
    score(name);
    step();  // held while req high
    check({name, "_rv_hold"}, resp_valid, 1);
    check({name, "_rd_hold"}, resp_data, exp);
    req = 1'b0;
    step();
    check({name, "_rv_drop"}, resp_valid, 0);
    check({name, "_busy_drop"}, busy, 0);
    check({name, "_rd_keep"}, resp_data, exp);
  endtask

  typedef struct {
    logic       w;
    logic [2:0] a;
    logic [3:0] d;
    logic [3:0] exp;
  } txn_t;

  typedef struct {
    logic [2:0] a;
    logic [3:0] exp;
  } dbg_vec_t;

  txn_t     txns[8];
  dbg_vec_t dvec[8];

  initial begin
    // stimulus tables (expected values computed by hand)
    for (int i = 0; i < 8; i++) begin
      dvec[i].a   = 3'(i);
      dvec[i].exp = 4'(i);
    end
    txns[0] = '{w: 1'b0, a: 3'd5, d: 4'h0, exp: 4'h5};
    txns[1] = '{w: 1'b1, a: 3'd3, d: 4'hA, exp: 4'hA};
    txns[2] = '{w: 1'b0, a: 3'd3, d: 4'h7, exp: 4'hA};
    txns[3] = '{w: 1'b1, a: 3'd0, d: 4'hC, exp: 4'hC};
    txns[4] = '{w: 1'b0, a: 3'd0, d: 4'h0, exp: 4'hC};
    txns[5] = '{w: 1'b0, a: 3'd7, d: 4'h0, exp: 4'h7};
    txns[6] = '{w: 1'b1, a: 3'd7, d: 4'h1, exp: 4'h1};
    txns[7] = '{w: 1'b0, a: 3'd7, d: 4'h0, exp: 4'h1};

    reset = 1'b1; req = 1'b0; req_write = 1'b0; req_address = '0; req_data = '0;
    dbg_address = '0;
    step();
    step();
    reset = 1'b0;
    step();

    // 1: reset state and memory contents
    check("reset_rv", resp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_rd", resp_data, 0);
    for (int i = 0; i < 8; i++) peek($sformatf("reset_mem%0d", i), dvec[i].a, dvec[i].exp);

    // 2,3: reads and write-backs from the table
    for (int i = 0; i < 8; i++) do_txn($sformatf("txn%0d", i), txns[i].w, txns[i].a, txns[i].d, txns[i].exp);
    peek("dbg_after_wr3", 3'd3, 4'hA);
    peek("dbg_after_wr0", 3'd0, 4'hC);
    peek("dbg_after_wr7", 3'd7, 4'h1);

    // 4: req held through ACK; inputs changed during BUSY are ignored
    req = 1'b1; req_write = 1'b0; req_address = 3'd1; req_data = 4'h0;
    exp_q.push_back(4'h1);
    step();
    req_write = 1'b1; req_address = 3'd4; req_data = 4'h9;
    check("hold_busy", busy, 1);
    step();
    step();
    check("hold_rv", resp_valid, 1);
    score("hold");
    step();
    step();
    check("hold_rv_long", resp_valid, 1);
    check("hold_busy_long", busy, 1);
    peek("hold_no_wr4", 3'd4, 4'h4);
    req = 1'b0;
    step();
    check("hold_idle_rv", resp_valid, 0);
    check("hold_idle_busy", busy, 0);
    req = 1'b1; req_write = 1'b0; req_address = 3'd4;
    exp_q.push_back(4'h4);
    step();
    check("second_capture", busy, 1);
    check("second_rv0", resp_valid, 0);
    step();
    step();
    check("second_rv", resp_valid, 1);
    score("second");
    req = 1'b0;
    step();
    check("second_drop", resp_valid, 0);

    // 5: reset one cycle after capturing a write
    req = 1'b1; req_write = 1'b1; req_address = 3'd6; req_data = 4'hF;
    step();
    check("rst_mid_busy", busy, 1);
    req = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_rv", resp_valid, 0);
    check("rst_mid_idle", busy, 0);
    peek("rst_mid_mem6", 3'd6, 4'h6);
    peek("rst_mid_mem3", 3'd3, 4'h3);
    step();
    step();
    check("rst_mid_rv_later", resp_valid, 0);
    peek("rst_mid_mem6_later", 3'd6, 4'h6);

    // 6: req pulsed for a single cycle
    req = 1'b1; req_write = 1'b0; req_address = 3'd2;
    exp_q.push_back(4'h2);
    step();
    req = 1'b0;
    check("pulse_busy", busy, 1);
    step();
    check("pulse_rv_e1", resp_valid, 0);
    step();
    check("pulse_rv", resp_valid, 1);
    score("pulse");
    step();
    check("pulse_rv_off", resp_valid, 0);
    check("pulse_idle", busy, 0);
    step();
    check("pulse_stay_idle", busy, 0);

    // debug port is read-before-write at the commit edge
    dbg_address = 3'd2;
    req = 1'b1; req_write = 1'b1; req_address = 3'd2; req_data = 4'hE;
    exp_q.push_back(4'hE);
    step();
    step();
    check("rbw_old", dbg_data, 4'h2);
    step();
    check("rbw_new", dbg_data, 4'hE);
    score("rbw");
    req = 1'b0;
    step();
    check("rbw_done", busy, 0);

    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_memory_responder.md
Name: bus_memory_responder

Overview:
- Shared-memory end of the CPU/cache bus protocol. Accepts read-miss and write-back requests issued by the bus side and answers them from an 8-word x 4-bit backing store after a fixed latency.
- Uses a 4-phase req/resp handshake.
- Instantiated beside the bus block inside the board top level.
- A debug read port drives a board display without disturbing transactions.

Parameters:
- ADDR_WIDTH, 3, word address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 4, word width.
- LATENCY, 2, capture-to-response delay in cycles; legal range 1..15.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request valid from bus; held high until resp_valid observed.
- req_write  input  1  1 = write-back, 0 = read; sampled with req.
- req_address  input  ADDR_WIDTH  target word; sampled with req.
- req_data  input  DATA_WIDTH  write-back data; sampled with req, ignored for reads.
- resp_valid  output  1  response available (read data valid / write committed).
- resp_data  output  DATA_WIDTH  read data, or echo of written data for writes.
- busy  output  1  high whenever state != IDLE.
- dbg_address  input  ADDR_WIDTH  debug peek address.
- dbg_data  output  DATA_WIDTH  combinational mem[dbg_address].

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; resp_valid = 0; resp_data = 0; busy = 0; counter = 0.
  - mem[i] = i mod 2**DATA_WIDTH for every i.
  - Reset mid-transaction discards the captured request; no write commits.
- IDLE:
  - If req = 1 at an edge: latch req_write, req_address and req_data; counter = LATENCY-1; go to BUSY.
  - If req = 0: stay in IDLE.
- BUSY:
  - If counter != 0: decrement.
  - If counter == 0, go to ACK at this edge and:
    - Read: resp_data <= mem[latched address].
    - Write: mem[latched address] <= latched data; resp_data <= latched data.
    - resp_valid <= 1.
  - Consequence: if req is captured at edge E0, resp_valid first rises after edge E0+LATENCY.
- ACK:
  - resp_valid and resp_data are held while req = 1.
  - At the first edge with req = 0: resp_valid <= 0, go to IDLE. resp_data keeps its last value.
- New requests are accepted only in IDLE. At least one IDLE cycle separates consecutive transactions; back-to-back throughput is LATENCY+2 cycles.
- Input changes after capture:
  - req_write, req_address and req_data are ignored until the next IDLE capture.
  - If req drops during BUSY (protocol violation), the transaction still completes. ACK is then exited at the next edge, so resp_valid is a 1-cycle pulse.
- dbg_data:
  - Combinational from the array.
  - Shows a write's new value from the cycle after the BUSY->ACK edge.
  - Reading the same address at the commit edge returns the old value (read-before-write on the debug port).
- Widths: addresses are never out of range (full decode of 2**ADDR_WIDTH words); no arithmetic on data.
- FSM encoding: 2 bits (IDLE=0, BUSY=1, ACK=2). The unused code 3 returns to IDLE with resp_valid = 0.

Test Plan:
1. Reset, then sweep dbg_address 0..7 -> dbg_data = 0..7; resp_valid = 0, busy = 0.
2. LATENCY=2: read, address 5 -> busy after E0; resp_valid = 1 and resp_data = 5 after E0+2, held until req drops; resp_valid = 0 one edge after req = 0.
3. Write-back, address 3, data 0xA -> resp_data = 0xA after E0+2; dbg_data[3] = 0xA afterwards; a subsequent read of 3 returns 0xA.
4. req held high continuously through two transactions -> second capture only after req drops and state returns to IDLE; no overlap; address/data changed during BUSY are ignored.
5. Assert reset one cycle after capturing a write to address 6 with data 0xF -> IDLE, resp_valid = 0, mem[6] = 6 (no commit).
6. req pulsed high for 1 cycle only (read, address 2) -> single-cycle resp_valid pulse with resp_data = 2, then IDLE.
